// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator: opcodes, format codes and
// the occupancy encoding of the output skid buffer.
package imm_gen_pipe_pkg;

   // RV32/RV64 base opcodes that select a non-I immediate format
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   // Immediate format code as presented on out_type; 6 and 7 are never produced
   typedef enum logic [2:0] {
      ImmI = 3'd0,
      ImmS = 3'd1,
      ImmB = 3'd2,
      ImmU = 3'd3,
      ImmJ = 3'd4,
      ImmZ = 3'd5
   } imm_type_e;

   // Number of decoded entries held in the skid buffer
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } occ_state_e;

   // Format select from the opcode; SYSTEM uses the CSR immediate only for
   // the *I variants, which are flagged by funct3[2] (inst[14]).
   function automatic imm_type_e imm_format(input logic [6:0] opcode,
                                            input logic       funct3_msb);
      imm_type_e fmt;
      case (opcode)
         OpBranch: fmt = ImmB;
         OpStore:  fmt = ImmS;
         OpJal:    fmt = ImmJ;
         OpLui:    fmt = ImmU;
         OpAuipc:  fmt = ImmU;
         OpSystem: fmt = funct3_msb ? ImmZ : ImmI;
         default:  fmt = ImmI;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decode: instruction word -> immediate and
// format code. Every format is assembled as a 32-bit value and then
// sign-extended to XLEN; the CSR immediate has bit 31 clear, so the same
// extension zero-fills it.
module imm_decode
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_inst,
   output logic [XLEN-1:0] o_imm,
   output imm_type_e       o_type
);

   imm_type_e   w_type;
   logic [31:0] w_imm32;

   // Pick the format and gather its bit fields into a 32-bit immediate
   always_comb begin
      w_type  = imm_format(i_inst[6:0], i_inst[14]);
      w_imm32 = '0;
      case (w_type)
         ImmS: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         ImmB: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                          i_inst[11:8], 1'b0};
         ImmU: w_imm32 = {i_inst[31:12], 12'b0};
         ImmJ: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
         ImmZ: w_imm32 = {27'b0, i_inst[19:15]};
         default: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      endcase
   end

   // Signed cast makes the width conversion replicate bit 31 (U included on RV64)
   assign o_imm  = XLEN'($signed(w_imm32));
   assign o_type = w_type;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry output skid buffer. Decode happens
// ahead of the buffer so the stored entries are already final results; the
// head entry drives the outputs and the skid entry absorbs the one extra
// instruction that can arrive while in_ready (a registered signal) is still
// high during downstream backpressure.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned PASS_INST = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_type,
   output logic [31:0]     out_inst
);

   occ_state_e      r_state;
   occ_state_e      w_state_next;
   logic            r_in_ready;

   logic [XLEN-1:0] r_head_imm;
   logic [2:0]      r_head_type;
   logic [31:0]     r_head_inst;
   logic [XLEN-1:0] r_skid_imm;
   logic [2:0]      r_skid_type;
   logic [31:0]     r_skid_inst;

   logic [XLEN-1:0] w_dec_imm;
   imm_type_e       w_dec_type;
   logic [31:0]     w_keep_inst;

   logic            w_in_xfer;
   logic            w_out_xfer;
   logic            w_head_from_in;
   logic            w_head_from_skid;
   logic            w_skid_from_in;

   imm_decode #(
      .XLEN (XLEN)
   ) u_imm_decode (
      .i_inst (in_inst),
      .o_imm  (w_dec_imm),
      .o_type (w_dec_type)
   );

   // Instruction word is only carried when requested; otherwise it stays zero
   assign w_keep_inst = (PASS_INST != 0) ? in_inst : 32'd0;

   // Transfer qualifiers; flush overrides both directions
   assign w_in_xfer  = in_valid & r_in_ready & ~flush;
   assign w_out_xfer = out_valid & out_ready & ~flush;

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Occupancy next-state: accept raises it, drain lowers it, both together hold it
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = StEmpty;
      end else begin
         case (r_state)
            StEmpty: begin
               if (w_in_xfer) w_state_next = StOne;
            end
            StOne: begin
               if (w_in_xfer && !w_out_xfer) begin
                  w_state_next = StFull;
               end else if (!w_in_xfer && w_out_xfer) begin
                  w_state_next = StEmpty;
               end
            end
            StFull: begin
               if (w_out_xfer) w_state_next = StOne;
            end
            default: w_state_next = StEmpty;
         endcase
      end
   end

   // Output decode of the occupancy state
   always_comb begin
      out_valid = (r_state != StEmpty);
      in_ready  = r_in_ready;
      out_imm   = r_head_imm;
      out_type  = r_head_type;
      out_inst  = r_head_inst;
   end

   // in_ready mirrors "skid entry will be empty", registered so it never
   // follows out_ready combinationally; held low throughout reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= (w_state_next != StFull);
      end
   end

   // Steering of the buffer entries for the current cycle
   always_comb begin
      w_head_from_in   = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         StEmpty: w_head_from_in = w_in_xfer;
         StOne: begin
            w_head_from_in = w_in_xfer & w_out_xfer;
            w_skid_from_in = w_in_xfer & ~w_out_xfer;
         end
         StFull:  w_head_from_skid = w_out_xfer;
         default: ;
      endcase
   end

   // Head entry: loaded from the decoder or promoted from the skid entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_imm  <= '0;
         r_head_type <= 3'd0;
         r_head_inst <= 32'd0;
      end else if (w_head_from_in) begin
         r_head_imm  <= w_dec_imm;
         r_head_type <= w_dec_type;
         r_head_inst <= w_keep_inst;
      end else if (w_head_from_skid) begin
         r_head_imm  <= r_skid_imm;
         r_head_type <= r_skid_type;
         r_head_inst <= r_skid_inst;
      end
   end

   // Skid entry: captures an accepted instruction while the head is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_imm  <= '0;
         r_skid_type <= 3'd0;
         r_skid_inst <= 32'd0;
      end else if (w_skid_from_in) begin
         r_skid_imm  <= w_dec_imm;
         r_skid_type <= w_dec_type;
         r_skid_inst <= w_keep_inst;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32 instance (instruction passed
// through) and an RV64 instance (instruction not passed) share one stimulus
// stream. The driver queues the expected result on every accepted
// instruction; per-instance monitors pop and compare on every output transfer.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] imm;
      logic [2:0]  typ;
   } vec_t;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_inst;
   logic        flush;
   logic        out_ready;

   logic        in_ready32, out_valid32;
   logic [31:0] out_imm32;
   logic [2:0]  out_type32;
   logic [31:0] out_inst32;

   logic        in_ready64, out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_type64;
   logic [31:0] out_inst64;

   vec_t vecs [13];
   exp_t q32[$];
   exp_t q64[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic stream_chk = 1'b0;
   int   w;

   imm_gen_pipe #(
      .XLEN      (32),
      .PASS_INST (1)
   ) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready32),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid32),
      .out_ready (out_ready),
      .out_imm   (out_imm32),
      .out_type  (out_type32),
      .out_inst  (out_inst32)
   );

   imm_gen_pipe #(
      .XLEN      (64),
      .PASS_INST (0)
   ) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready64),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid64),
      .out_ready (out_ready),
      .out_imm   (out_imm64),
      .out_type  (out_type64),
      .out_inst  (out_inst64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one instruction until accepted; returns wait cycles spent
   task automatic send(input int idx, output int waits);
      logic ok;
      ok = 1'b0;
      waits = 0;
      in_valid = 1'b1;
      in_inst  = vecs[idx].inst;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (in_ready32 && !flush) begin
            q32.push_back('{imm: vecs[idx].imm, typ: vecs[idx].typ, inst: vecs[idx].inst});
            q64.push_back('{imm: vecs[idx].imm, typ: vecs[idx].typ, inst: 32'd0});
            ok = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected acceptance, vec %0d",
                  idx);
      end
   endtask

   task automatic drain(input string name);
      repeat (4) @(posedge clk);
      #1;
      chk({name, "_q32_empty"}, 64'(q32.size()), 64'd0);
      chk({name, "_q64_empty"}, 64'(q64.size()), 64'd0);
   endtask

   // RV32 monitor; also checks continuous output while streaming
   always @(negedge clk) begin : mon32
      exp_t e;
      if (rst_n && !flush && out_valid32 && out_ready) begin
         if (q32.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out32_unexpected: got imm 0x%0h expected no output", out_imm32);
         end else begin
            e = q32.pop_front();
            chk("out32_imm", 64'(out_imm32), {32'd0, e.imm[31:0]});
            chk("out32_type", 64'(out_type32), 64'(e.typ));
            chk("out32_inst", 64'(out_inst32), 64'(e.inst));
         end
      end
      if (stream_chk) chk("stream_out_valid", 64'(out_valid32), 64'd1);
   end

   // RV64 monitor
   always @(negedge clk) begin : mon64
      exp_t e;
      if (rst_n && !flush && out_valid64 && out_ready) begin
         if (q64.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out64_unexpected: got imm 0x%0h expected no output", out_imm64);
         end else begin
            e = q64.pop_front();
            chk("out64_imm", out_imm64, e.imm);
            chk("out64_type", 64'(out_type64), 64'(e.typ));
            chk("out64_inst", 64'(out_inst64), 64'(e.inst));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish before 100us");
      $fatal(1, "timeout");
   end

   initial begin
      // inst, sign/zero-extended 64-bit immediate, format code
      vecs[0]  = '{inst: 32'hFFF00093, imm: 64'hFFFFFFFFFFFFFFFF, typ: 3'd0};
      vecs[1]  = '{inst: 32'hFE000EE3, imm: 64'hFFFFFFFFFFFFFFFC, typ: 3'd2};
      vecs[2]  = '{inst: 32'h12345037, imm: 64'h0000000012345000, typ: 3'd3};
      vecs[3]  = '{inst: 32'h800000B7, imm: 64'hFFFFFFFF80000000, typ: 3'd3};
      vecs[4]  = '{inst: 32'h300FD073, imm: 64'h000000000000001F, typ: 3'd5};
      vecs[5]  = '{inst: 32'hFE20AC23, imm: 64'hFFFFFFFFFFFFFFF8, typ: 3'd1};
      vecs[6]  = '{inst: 32'h0080006F, imm: 64'h0000000000000008, typ: 3'd4};
      vecs[7]  = '{inst: 32'h30009073, imm: 64'h0000000000000300, typ: 3'd0};
      vecs[8]  = '{inst: 32'hFFFFF017, imm: 64'hFFFFFFFFFFFFF000, typ: 3'd3};
      vecs[9]  = '{inst: 32'hFFDFF0EF, imm: 64'hFFFFFFFFFFFFFFFC, typ: 3'd4};
      vecs[10] = '{inst: 32'h00000863, imm: 64'h0000000000000010, typ: 3'd2};
      vecs[11] = '{inst: 32'h3402D073, imm: 64'h0000000000000005, typ: 3'd5};
      vecs[12] = '{inst: 32'h7FF02083, imm: 64'h00000000000007FF, typ: 3'd0};

      rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; flush = 1'b0; out_ready = 1'b0;

      // Reset state
      #7;
      chk("rst_out_valid", 64'(out_valid32), 64'd0);
      chk("rst_out_imm", 64'(out_imm32), 64'd0);
      chk("rst_out_type", 64'(out_type32), 64'd0);
      chk("rst_out_inst", 64'(out_inst32), 64'd0);
      chk("rst_in_ready32", 64'(in_ready32), 64'd0);
      chk("rst_in_ready64", 64'(in_ready64), 64'd0);
      chk("rst_out_imm64", out_imm64, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_before_edge", 64'(in_ready32), 64'd0);
      @(posedge clk);
      #1;
      chk("in_ready_after_edge32", 64'(in_ready32), 64'd1);
      chk("in_ready_after_edge64", 64'(in_ready64), 64'd1);

      // Streaming every vector back to back with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         send(i, w);
         chk("stream_in_ready_wait", 64'(w), 64'd0);
         if (i == 0) stream_chk = 1'b1;
      end
      @(posedge clk);
      #1 stream_chk = 1'b0;
      drain("stream");

      // Backpressure: A then B fill the buffer
      out_ready = 1'b0;
      send(1, w);
      send(2, w);
      @(negedge clk);
      chk("bp_full_in_ready", 64'(in_ready32), 64'd0);
      chk("bp_full_out_valid", 64'(out_valid32), 64'd1);
      chk("bp_head_imm", 64'(out_imm32), {32'd0, vecs[1].imm[31:0]});
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_imm", 64'(out_imm32), {32'd0, vecs[1].imm[31:0]});
      chk("bp_hold_type", 64'(out_type32), 64'(vecs[1].typ));
      chk("bp_hold_in_ready", 64'(in_ready32), 64'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_a_leaving_in_ready", 64'(in_ready32), 64'd0);
      @(negedge clk);
      chk("bp_after_a_in_ready", 64'(in_ready32), 64'd1);
      chk("bp_b_out_valid", 64'(out_valid32), 64'd1);
      drain("backpressure");

      // Flush while full with a new instruction offered
      out_ready = 1'b0;
      send(3, w);
      send(4, w);
      in_valid = 1'b1;
      in_inst  = vecs[5].inst;
      flush    = 1'b1;
      @(posedge clk);
      q32.delete();
      q64.delete();
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid32", 64'(out_valid32), 64'd0);
      chk("flush_in_ready32", 64'(in_ready32), 64'd1);
      chk("flush_out_valid64", 64'(out_valid64), 64'd0);
      chk("flush_in_ready64", 64'(in_ready64), 64'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(6, w);
      drain("flush");

      // Asynchronous reset while full
      out_ready = 1'b0;
      send(7, w);
      send(8, w);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid32), 64'd0);
      chk("midrst_out_imm", 64'(out_imm32), 64'd0);
      chk("midrst_out_type", 64'(out_type32), 64'd0);
      chk("midrst_out_inst", 64'(out_inst32), 64'd0);
      chk("midrst_in_ready", 64'(in_ready32), 64'd0);
      chk("midrst_out_imm64", out_imm64, 64'd0);
      q32.delete();
      q64.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(9, w);
      drain("reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
